// File: rtl/uart_rx_fifo_if.sv
// Handshake and status bundle between the UART receiver, the drain/FIFO stage and the core.
// Signal names follow the receiver's existing port names.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          d_valid;
  logic [7:0]    rx_data_out;
  logic          overflow;
  logic          SFE;
  logic          Rd_en;
  logic          clr_ovrflw;
  logic          pop;
  logic [7:0]    dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          ovr_err;
  logic          frm_err;
  logic          clr_err;

  modport slave (
    input  d_valid, rx_data_out, overflow, SFE, pop, clr_err,
    output Rd_en, clr_ovrflw, dout, empty, full, count, ovr_err, frm_err
  );

  modport master (
    output d_valid, rx_data_out, overflow, SFE, pop, clr_err,
    input  Rd_en, clr_ovrflw, dout, empty, full, count, ovr_err, frm_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Drains bytes from the UART receiver holding buffer into a first-word-fall-through FIFO
// and keeps sticky overflow / framing error status.
//
// state | meaning
// IDLE  | ready; accept the held byte when there is room (or a pop frees a slot)
// ACK   | Rd_en high for this single cycle
// WAIT  | byte taken; hold until the receiver drops d_valid
module uart_rx_fifo #(
  parameter int AW = 4
) (
  input  logic            CLOCK,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);
  localparam int            DEPTH    = 2 ** AW;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            rd_en_q;
  logic            clr_ovrflw_q;
  logic            ovf_q;
  logic            ovr_err_q;
  logic            frm_err_q;
  logic            empty_c;
  logic            full_c;
  logic            do_wr;
  logic            do_rd;

  assign empty_c = (count == '0);
  assign full_c  = (count == FULL_CNT);
  // A pop in the same cycle frees the head slot, so a full FIFO may still accept.
  assign do_wr   = (state == IDLE) && bus.d_valid && (!full_c || bus.pop);
  assign do_rd   = bus.pop && !empty_c;

  always_ff @(posedge CLOCK) begin
    if (!reset) begin
      state   <= IDLE;
      rd_en_q <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (do_wr) begin
            state   <= ACK;
            rd_en_q <= 1'b1;
          end
        end
        ACK:     state <= WAIT;
        WAIT:    if (!bus.d_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset && do_wr) mem[wr_ptr] <= bus.rx_data_out;
  end

  always_ff @(posedge CLOCK) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // clr_ovrflw fires on the rising edge of overflow only; set beats clear on the sticky bits.
  always_ff @(posedge CLOCK) begin
    if (!reset) begin
      ovf_q        <= 1'b0;
      clr_ovrflw_q <= 1'b0;
      ovr_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
    end else begin
      ovf_q        <= bus.overflow;
      clr_ovrflw_q <= bus.overflow && !ovf_q;
      if (bus.overflow)     ovr_err_q <= 1'b1;
      else if (bus.clr_err) ovr_err_q <= 1'b0;
      if (bus.SFE)          frm_err_q <= 1'b1;
      else if (bus.clr_err) frm_err_q <= 1'b0;
    end
  end

  assign bus.Rd_en      = rd_en_q;
  assign bus.clr_ovrflw = clr_ovrflw_q;
  assign bus.dout       = empty_c ? 8'h00 : mem[rd_ptr];
  assign bus.empty      = empty_c;
  assign bus.full       = full_c;
  assign bus.count      = count;
  assign bus.ovr_err    = ovr_err_q;
  assign bus.frm_err    = frm_err_q;
endmodule
